pattern_sig_compactor: RTL and testbench
========================================

# pattern_sig_compactor

Response-compaction stage that sits directly downstream of the merged pattern netlist blocks. It takes the eight registered response bits each cycle and folds them into an 8-bit multiple-input signature register (MISR) over a programmable window. It then compares the result against a golden signature and reports pass/fail. A small control FSM sequences the warm-up flush, the capture window and result hold.

## Interface
Parameters:
- WIDTH, 8, response/signature width
- POLY, 8'h1D, MISR feedback taps (x^8+x^4+x^3+x^2+1, bit 8 implicit)
- SEED, 8'h00, signature value loaded on reset, start and abort
- WARMUP, 2, cycles ignored after start so upstream flops flush (0 allowed)
- LEN_W, 16, width of window length

Ports:
- blif_clk_net  in  1  single clock, all state on rising edge
- blif_reset_net  in  1  asynchronous, active-high reset
- resp_in  in  WIDTH  upstream response, bit order [7:0] = {P6, ACVQN1, G199, n_42, n_549, n_573, n_572, G42}
- start  in  1  begin a capture run (honoured only in IDLE or DONE)
- abort  in  1  return to IDLE, reseed
- len  in  LEN_W  capture window in cycles, sampled with start
- golden  in  WIDTH  expected signature, compared continuously in DONE
- busy  out  1  high in WARM or RUN
- done  out  1  high in DONE
- pass  out  1  done && (sig == golden)
- sig  out  WIDTH  current signature
- count  out  LEN_W  samples folded so far

## Operation
- States: IDLE, WARM, RUN, DONE. Encoding is free; one-hot is preferred.
- Reset values: state=IDLE, sig=SEED, count=0, wcnt=0, len_q=0. Outputs busy=0, done=0, pass=0.
- IDLE/DONE with start=1:
  - len_q←len, sig←SEED, count←0, wcnt←0.
  - Go to WARM. If WARMUP=0, go to RUN; if additionally len=0, go to DONE.
- WARM:
  - wcnt increments each cycle and resp_in is ignored.
  - When wcnt reaches WARMUP-1, go to RUN, or to DONE if len_q=0.
- RUN, each cycle: sig←((sig<<1) truncated to WIDTH) ^ (sig[WIDTH-1] ? POLY : 0) ^ resp_in, and count++. On the edge where count+1 == len_q, go to DONE.
- DONE:
  - sig and count hold.
  - pass tracks golden combinationally.
  - Stays in DONE until start (restart) or abort.
- abort (any state) has priority over start. Next state is IDLE, sig←SEED, count←0.
- start while busy is ignored; len and golden changes mid-run are ignored except golden in DONE.
- count saturates at len_q and never wraps. len=2^LEN_W-1 is legal.

## Timing
- Call the edge that samples start edge 0.
- busy rises after edge 0 (registered).
- The first resp_in folded into sig is the one present at edge WARMUP+1.
- The last sample is taken at edge WARMUP+len. done rises after that edge, in the same cycle busy falls.
- Total start-to-done: WARMUP+len cycles. For len=0: WARMUP cycles, or 1 cycle if WARMUP=0.
- pass is valid in the same cycle as done (combinational compare on registered sig).
- Asynchronous reset mid-run immediately forces all reset values. No partial signature is retained.
- A restart from DONE drops done on the next edge.

## Structure
- Shared package holds the state enum, WIDTH/POLY/SEED defaults, and the resp_in bit-index constants matching the upstream output names.
- One sub-module, misr_step: a pure combinational next-signature function (sig, resp, POLY → sig_next). It is reused by the bench's reference model.
- All flops use async active-high reset on blif_reset_net, matching the DFFARX1-based stages.

## Test plan
- Reset, then start with len=1, WARMUP=2, resp_in=8'h5A at edge 3. Expect done after edge 3, sig=8'h5A, count=1; golden=8'h5A gives pass=1.
- len=2, resp_in 8'h80 then 8'h01. Expect sig 8'h80, then 8'h1C (feedback applied); golden=8'h1D gives pass=0.
- len=0, WARMUP=0: expect done 1 cycle after start, sig=8'h00, count=0.
- Abort asserted together with start, and separately at RUN sample 3 of len=10. Expect IDLE on the next edge, sig=SEED, busy=0, done never rises.
- Async reset pulse mid-RUN, between edges. Outputs go to reset values immediately; a subsequent start with len=4 produces the same signature as a clean run.
- Start held high through RUN: no restart occurs. In DONE it restarts, done drops one edge later and the new window produces an independent signature.

Source files
------------

// File: rtl/pattern_sig_compactor_pkg.sv
// Shared types and constants for the response-compaction stage: FSM states,
// signature defaults and the upstream bit positions inside resp_in.
package pattern_sig_compactor_pkg;

    localparam int         DEF_WIDTH = 8;
    localparam logic [7:0] DEF_POLY  = 8'h1D;
    localparam logic [7:0] DEF_SEED  = 8'h00;

    typedef enum logic [3:0] {
        S_IDLE = 4'b0001,
        S_WARM = 4'b0010,
        S_RUN  = 4'b0100,
        S_DONE = 4'b1000
    } state_e;

    // resp_in bit positions, named after the upstream register outputs
    localparam int RESP_G42    = 0;
    localparam int RESP_N_572  = 1;
    localparam int RESP_N_573  = 2;
    localparam int RESP_N_549  = 3;
    localparam int RESP_N_42   = 4;
    localparam int RESP_G199   = 5;
    localparam int RESP_ACVQN1 = 6;
    localparam int RESP_P6     = 7;

endpackage

// File: rtl/pattern_sig_compactor_misr_step.sv
// One MISR fold: shift left, apply feedback taps when the MSB falls out,
// then XOR in the parallel response word.
module misr_step
    import pattern_sig_compactor_pkg::*;
#(
    parameter int               WIDTH = DEF_WIDTH,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(DEF_POLY)
) (
    input  logic [WIDTH-1:0] sig,
    input  logic [WIDTH-1:0] resp,
    output logic [WIDTH-1:0] sig_next
);

    always_comb begin
        sig_next = {sig[WIDTH-2:0], 1'b0} ^ (sig[WIDTH-1] ? POLY : '0) ^ resp;
    end

endmodule

// File: rtl/pattern_sig_compactor.sv
// MISR response compactor: warm-up flush, capture window of len samples,
// then hold the signature and compare it against golden.
module pattern_sig_compactor
    import pattern_sig_compactor_pkg::*;
#(
    parameter int               WIDTH  = DEF_WIDTH,
    parameter logic [WIDTH-1:0] POLY   = WIDTH'(DEF_POLY),
    parameter logic [WIDTH-1:0] SEED   = WIDTH'(DEF_SEED),
    parameter int               WARMUP = 2,
    parameter int               LEN_W  = 16
) (
    input  logic             blif_clk_net,
    input  logic             blif_reset_net,
    input  logic [WIDTH-1:0] resp_in,
    input  logic             start,
    input  logic             abort,
    input  logic [LEN_W-1:0] len,
    input  logic [WIDTH-1:0] golden,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH-1:0] sig,
    output logic [LEN_W-1:0] count,
    output state_e           state_dbg
);

    localparam int  WC_W    = (WARMUP > 1) ? $clog2(WARMUP) : 1;
    localparam bit  NO_WARM = (WARMUP == 0);

    // Handshake: start is a request accepted only when busy=0; done is a level
    // that holds (with sig/pass valid) until the next accepted start or abort.
    state_e           state, state_n;
    logic [WIDTH-1:0] sig_n, sig_fold;
    logic [LEN_W-1:0] count_n, len_q, len_n;
    logic [WC_W-1:0]  wcnt, wcnt_n;

    misr_step #(.WIDTH(WIDTH), .POLY(POLY)) u_step (
        .sig      (sig),
        .resp     (resp_in),
        .sig_next (sig_fold)
    );

    always_comb begin
        state_n = state;
        sig_n   = sig;
        count_n = count;
        wcnt_n  = wcnt;
        len_n   = len_q;
        if (abort) begin
            state_n = S_IDLE;
            sig_n   = SEED;
            count_n = '0;
            wcnt_n  = '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        len_n   = len;
                        sig_n   = SEED;
                        count_n = '0;
                        wcnt_n  = '0;
                        if (NO_WARM) state_n = (len == '0) ? S_DONE : S_RUN;
                        else         state_n = S_WARM;
                    end
                end
                S_WARM: begin
                    wcnt_n = wcnt + 1'b1;
                    if (wcnt == WC_W'(WARMUP - 1))
                        state_n = (len_q == '0) ? S_DONE : S_RUN;
                end
                S_RUN: begin
                    sig_n = sig_fold;
                    // count stops at len_q, so it cannot wrap even at the max length
                    if (count != len_q) count_n = count + 1'b1;
                    if (count + 1'b1 == len_q) state_n = S_DONE;
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge blif_clk_net or posedge blif_reset_net) begin
        if (blif_reset_net) begin
            state <= S_IDLE;
            sig   <= SEED;
            count <= '0;
            wcnt  <= '0;
            len_q <= '0;
        end else begin
            state <= state_n;
            sig   <= sig_n;
            count <= count_n;
            wcnt  <= wcnt_n;
            len_q <= len_n;
        end
    end

    assign busy      = (state == S_WARM) || (state == S_RUN);
    assign done      = (state == S_DONE);
    assign pass      = done && (sig == golden);
    assign state_dbg = state;

endmodule

// File: tb/tb_pattern_sig_compactor.sv
// Self-checking bench for pattern_sig_compactor: table vectors, random windows
// against a polynomial-arithmetic model, and abort/reset/restart sequences.
module tb_pattern_sig_compactor;
    import pattern_sig_compactor_pkg::*;

    localparam int         WARM   = 2;
    localparam logic [7:0] SEED_V = 8'h00;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  resp = '0;
    logic        start = 1'b0, abort = 1'b0;
    logic [15:0] len = '0;
    logic [7:0]  golden = '0;
    logic        busy, done, pass;
    logic [7:0]  sig;
    logic [15:0] count;
    state_e      st;

    logic        start0 = 1'b0, abort0 = 1'b0;
    logic [15:0] len0 = '0;
    logic        busy0, done0, pass0;
    logic [7:0]  sig0;
    logic [15:0] count0;
    state_e      st0;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] exp_q[$];
    logic [7:0] stim_q[$];
    logic [7:0] last_sig;

    always #5 clk = ~clk;

    pattern_sig_compactor #(.WARMUP(WARM)) dut (
        .blif_clk_net(clk), .blif_reset_net(rst), .resp_in(resp), .start(start),
        .abort(abort), .len(len), .golden(golden), .busy(busy), .done(done),
        .pass(pass), .sig(sig), .count(count), .state_dbg(st)
    );

    pattern_sig_compactor #(.WARMUP(0)) dut0 (
        .blif_clk_net(clk), .blif_reset_net(rst), .resp_in(resp), .start(start0),
        .abort(abort0), .len(len0), .golden(golden), .busy(busy0), .done(done0),
        .pass(pass0), .sig(sig0), .count(count0), .state_dbg(st0)
    );

    // Signature as polynomial arithmetic over GF(2): multiply by x modulo
    // x^8+x^4+x^3+x^2+1, then add the response word.
    function automatic logic [7:0] ref_fold(input logic [7:0] s, input logic [7:0] r);
        logic [8:0] p;
        p = {s, 1'b0};
        if (p[8]) p = p ^ 9'h11D;
        return p[7:0] ^ r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Edge 0: start sampled together with len.
    task automatic begin_run(input int l, input bit hold);
        start = 1'b1;
        len   = 16'(l);
        step();
        if (!hold) start = 1'b0;
    endtask

    // Edges 1..WARM+l: warm-up then capture, checking each folded sample.
    task automatic finish_run(input int l, input bit hold);
        logic [7:0] m, r;
        m = SEED_V;
        for (int e = 1; e <= WARM + l; e++) begin
            chk("busy_run", 32'(busy), 32'd1);
            chk("done_low", 32'(done), 32'd0);
            if (!hold) len = 16'($urandom_range(0, 65535));
            if (e > WARM) begin
                r = (stim_q.size() > 0) ? stim_q.pop_front() : 8'($urandom_range(0, 255));
                resp = r;
                m = ref_fold(m, r);
                exp_q.push_back(m);
            end else begin
                resp = 8'($urandom_range(0, 255));
            end
            step();
            if (e > WARM) begin
                chk("sig_step", 32'(sig), 32'(exp_q.pop_front()));
                chk("count_step", 32'(count), 32'(e - WARM));
            end
        end
        chk("done_end", 32'(done), 32'd1);
        chk("busy_end", 32'(busy), 32'd0);
        chk("count_end", 32'(count), 32'(l));
        chk("sig_end", 32'(sig), 32'(m));
        last_sig = m;
    endtask

    typedef struct {
        int         len;
        logic [7:0] r0, r1, gold, exp_sig;
        logic       exp_pass;
    } vec_t;

    vec_t vt[5];

    initial begin
        vt[0] = '{1, 8'h5A, 8'h00, 8'h5A, 8'h5A, 1'b1};
        vt[1] = '{2, 8'h80, 8'h01, 8'h1D, 8'h1C, 1'b0};
        vt[2] = '{2, 8'h80, 8'h01, 8'h1C, 8'h1C, 1'b1};
        vt[3] = '{2, 8'hFF, 8'h00, 8'hE3, 8'hE3, 1'b1};
        vt[4] = '{1, 8'h01, 8'h00, 8'h00, 8'h01, 1'b0};

        step();
        step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pass", 32'(pass), 32'd0);
        chk("rst_sig", 32'(sig), 32'(SEED_V));
        chk("rst_count", 32'(count), 32'd0);
        rst = 1'b0;
        step();

        // Table vectors
        for (int i = 0; i < 5; i++) begin
            stim_q.delete();
            stim_q.push_back(vt[i].r0);
            if (vt[i].len > 1) stim_q.push_back(vt[i].r1);
            golden = vt[i].gold;
            begin_run(vt[i].len, 1'b0);
            finish_run(vt[i].len, 1'b0);
            chk("tbl_sig", 32'(sig), 32'(vt[i].exp_sig));
            chk("tbl_pass", 32'(pass), 32'(vt[i].exp_pass));
        end

        // pass follows golden combinationally while in DONE
        golden = ~sig;
        #1 chk("pass_track_lo", 32'(pass), 32'd0);
        golden = last_sig;
        #1 chk("pass_track_hi", 32'(pass), 32'd1);
        step();
        chk("done_hold_sig", 32'(sig), 32'(last_sig));

        // len=0 with warm-up: done after WARM edges, empty signature
        begin_run(0, 1'b0);
        finish_run(0, 1'b0);

        // Random windows
        for (int i = 0; i < 6; i++) begin
            int l;
            l = $urandom_range(1, 12);
            stim_q.delete();
            begin_run(l, 1'b0);
            finish_run(l, 1'b0);
            golden = (i % 2 == 0) ? last_sig : (last_sig ^ 8'($urandom_range(1, 255)));
            #1 chk("rand_pass", 32'(pass), (i % 2 == 0) ? 32'd1 : 32'd0);
            step();
        end
        begin_run(300, 1'b0);
        finish_run(300, 1'b0);

        // abort together with start, from DONE
        start = 1'b1; abort = 1'b1; len = 16'd5;
        step();
        start = 1'b0; abort = 1'b0;
        chk("abst_busy", 32'(busy), 32'd0);
        chk("abst_done", 32'(done), 32'd0);
        chk("abst_sig", 32'(sig), 32'(SEED_V));
        chk("abst_count", 32'(count), 32'd0);
        step();
        chk("abst_idle", 32'(busy | done), 32'd0);

        // abort at the third RUN sample of a len=10 window
        begin_run(10, 1'b0);
        step();
        step();
        resp = 8'h33; step();
        resp = 8'hC5; step();
        chk("pre_abort_sig", 32'(sig), 32'(ref_fold(ref_fold(SEED_V, 8'h33), 8'hC5)));
        abort = 1'b1; resp = 8'h77;
        step();
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_sig", 32'(sig), 32'(SEED_V));
        chk("abort_count", 32'(count), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("abort_no_done", 32'(done), 32'd0);
        end

        // async reset between edges mid-RUN, then a clean len=4 run
        begin_run(4, 1'b0);
        step();
        step();
        resp = 8'hA7; step();
        resp = 8'h3C; step();
        rst = 1'b1;
        #1;
        chk("arst_sig", 32'(sig), 32'(SEED_V));
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        #1 rst = 1'b0;
        step();
        stim_q.delete();
        stim_q.push_back(8'hA7); stim_q.push_back(8'h3C);
        stim_q.push_back(8'h12); stim_q.push_back(8'hF0);
        begin_run(4, 1'b0);
        finish_run(4, 1'b0);
        chk("arst_clean_sig", 32'(sig),
            32'(ref_fold(ref_fold(ref_fold(ref_fold(SEED_V, 8'hA7), 8'h3C), 8'h12), 8'hF0)));

        // start held through RUN, then restart from DONE
        stim_q.delete();
        begin_run(4, 1'b1);
        finish_run(4, 1'b1);
        len = 16'd3;
        step();
        start = 1'b0;
        chk("restart_done_drop", 32'(done), 32'd0);
        chk("restart_busy", 32'(busy), 32'd1);
        chk("restart_sig_seed", 32'(sig), 32'(SEED_V));
        finish_run(3, 1'b0);

        // WARMUP=0 instance: len=0 done after one edge, len=1 samples edge 1
        start0 = 1'b1; len0 = 16'd0;
        step();
        start0 = 1'b0;
        chk("w0_done", 32'(done0), 32'd1);
        chk("w0_busy", 32'(busy0), 32'd0);
        chk("w0_sig", 32'(sig0), 32'(SEED_V));
        chk("w0_count", 32'(count0), 32'd0);
        start0 = 1'b1; len0 = 16'd1;
        step();
        start0 = 1'b0;
        chk("w0l1_busy", 32'(busy0), 32'd1);
        resp = 8'h9B;
        step();
        chk("w0l1_done", 32'(done0), 32'd1);
        chk("w0l1_sig", 32'(sig0), 32'(ref_fold(SEED_V, 8'h9B)));
        chk("w0l1_count", 32'(count0), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
